// File: rtl/fir_pkg.sv
// Shared state encoding and default widths for the FIR sequencer and its MAC.
package fir_pkg;

    localparam int RAM_LAT            = 1;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_TAP_NUM_WIDTH  = 10;
    localparam int DEF_DATA_NUM_WIDTH = 10;
    localparam int DEF_LEN_WIDTH      = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_IN,
        S_WRITE,
        S_MAC,
        S_DRAIN,
        S_OUT,
        S_DONE
    } fir_sched_state_e;

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate with synchronous clear; keeps the low W bits and
// wraps in two's complement, never saturates.
module fir_mac
    import fir_pkg::*;
#(
    parameter int W = DEF_DATA_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] coef,
    input  logic [W-1:0] sample,
    output logic [W-1:0] acc
);

    logic [W-1:0]        acc_q;
    logic [W-1:0]        acc_d;
    logic signed [W-1:0] prod;

    always_comb begin
        prod  = $signed(coef) * $signed(sample);
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + prod;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/fir_sched.sv
// FIR sequencer: circular sample buffer in data RAM, tap x data walk through fir_mac,
// one result per sample. Define FIR_SCHED_ZERO_INIT_EN to zero the buffer after start.
module fir_sched
    import fir_pkg::*;
#(
    parameter int pDATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int TAP_NUM_WIDTH  = DEF_TAP_NUM_WIDTH,
    parameter int DATA_NUM_WIDTH = DEF_DATA_NUM_WIDTH,
    parameter int LEN_WIDTH      = DEF_LEN_WIDTH
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      in_cfg_start,
    input  logic [TAP_NUM_WIDTH:0]    in_cfg_tap_num,
    input  logic [LEN_WIDTH-1:0]      in_cfg_data_len,
    input  logic                      in_cfg_done_clr,
    output logic                      out_sts_busy,
    output logic                      out_sts_done,
    output logic                      out_sts_idle,
    input  logic                      in_ss_tvalid,
    input  logic [pDATA_WIDTH-1:0]    in_ss_tdata,
    input  logic                      in_ss_tlast,
    output logic                      out_ss_tready,
    output logic                      out_sm_tvalid,
    output logic [pDATA_WIDTH-1:0]    out_sm_tdata,
    output logic                      out_sm_tlast,
    input  logic                      in_sm_tready,
    output logic                      out_tap_EN,
    output logic [TAP_NUM_WIDTH-1:0]  out_tap_A,
    input  logic [pDATA_WIDTH-1:0]    in_tap_Do,
    output logic                      out_data_EN,
    output logic                      out_data_WE,
    output logic [DATA_NUM_WIDTH-1:0] out_data_A,
    output logic [pDATA_WIDTH-1:0]    out_data_Di,
    input  logic [pDATA_WIDTH-1:0]    in_data_Do
);

    fir_sched_state_e            state_q, state_d;
    logic [TAP_NUM_WIDTH:0]      tap_num_q, tap_num_d;
    logic [LEN_WIDTH-1:0]        len_q, len_d;
    logic [LEN_WIDTH-1:0]        cnt_q, cnt_d;
    logic [TAP_NUM_WIDTH:0]      k_q, k_d;
    logic [DATA_NUM_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DATA_NUM_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [pDATA_WIDTH-1:0]      sample_q, sample_d;
    logic                        last_q, last_d;
    logic                        done_q, done_d;
    logic                        mac_en_q, mac_en_d;
    logic                        mac_clr;
    logic [pDATA_WIDTH-1:0]      acc;

    logic [TAP_NUM_WIDTH:0]      tap_num_m1;
    logic [DATA_NUM_WIDTH-1:0]   last_slot;
    logic                        k_at_end;
    logic                        start_ok;

`ifndef FIR_SCHED_ZERO_INIT_EN
    localparam int CMP_W = (LEN_WIDTH > TAP_NUM_WIDTH + 1) ? LEN_WIDTH : TAP_NUM_WIDTH + 1;
`endif

    assign tap_num_m1 = tap_num_q - (TAP_NUM_WIDTH + 1)'(1);
    assign last_slot  = DATA_NUM_WIDTH'(tap_num_m1);
    assign k_at_end   = (k_q == tap_num_m1);
    assign start_ok   = in_cfg_start && (in_cfg_tap_num != '0) && (in_cfg_data_len != '0)
                        && ((state_q == S_IDLE) || (state_q == S_DONE));

    assign out_sts_busy = (state_q != S_IDLE) && (state_q != S_DONE);
    assign out_sts_idle = !out_sts_busy;
    assign out_sts_done = done_q;

    fir_mac #(
        .W(pDATA_WIDTH)
    ) u_mac (
        .clk    (aclk),
        .rst    (areset),
        .clr    (mac_clr),
        .en     (mac_en_q),
        .coef   (in_tap_Do),
        .sample (in_data_Do),
        .acc    (acc)
    );

    always_comb begin
        state_d       = state_q;
        tap_num_d     = tap_num_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        k_d           = k_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        sample_d      = sample_q;
        last_d        = last_q;
        done_d        = in_cfg_done_clr ? 1'b0 : done_q;
        mac_en_d      = 1'b0;
        mac_clr       = 1'b0;
        out_ss_tready = 1'b0;
        out_sm_tvalid = 1'b0;
        out_sm_tdata  = '0;
        out_sm_tlast  = 1'b0;
        out_tap_EN    = 1'b0;
        out_tap_A     = '0;
        out_data_EN   = 1'b0;
        out_data_WE   = 1'b0;
        out_data_A    = '0;
        out_data_Di   = '0;

        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
`ifdef FIR_SCHED_ZERO_INIT_EN
            S_CLEAR: begin
                out_data_EN = 1'b1;
                out_data_WE = 1'b1;
                out_data_A  = DATA_NUM_WIDTH'(k_q);
                k_d         = k_q + (TAP_NUM_WIDTH + 1)'(1);
                if (k_at_end) begin
                    k_d     = '0;
                    state_d = S_WAIT_IN;
                end
            end
`endif
            S_WAIT_IN: begin
                out_ss_tready = 1'b1;
                if (in_ss_tvalid) begin
                    sample_d = in_ss_tdata;
                    cnt_d    = cnt_q + LEN_WIDTH'(1);
                    last_d   = in_ss_tlast || ((cnt_q + LEN_WIDTH'(1)) == len_q);
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                out_data_EN = 1'b1;
                out_data_WE = 1'b1;
                out_data_A  = wr_ptr_q;
                out_data_Di = sample_q;
                mac_clr     = 1'b1;
                k_d         = '0;
                rd_ptr_d    = wr_ptr_q;
                state_d     = S_MAC;
            end
            S_MAC: begin
                out_tap_EN  = 1'b1;
                out_tap_A   = k_q[TAP_NUM_WIDTH-1:0];
                out_data_EN = 1'b1;
                out_data_A  = rd_ptr_q;
`ifdef FIR_SCHED_ZERO_INIT_EN
                mac_en_d    = 1'b1;
`else
                // Only slots already holding a real sample of this job contribute.
                mac_en_d    = (CMP_W'(k_q) < CMP_W'(cnt_q));
`endif
                k_d         = k_q + (TAP_NUM_WIDTH + 1)'(1);
                rd_ptr_d    = (rd_ptr_q == '0) ? last_slot : rd_ptr_q - DATA_NUM_WIDTH'(1);
                if (k_at_end) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                wr_ptr_d = (wr_ptr_q == last_slot) ? '0 : wr_ptr_q + DATA_NUM_WIDTH'(1);
                state_d  = S_OUT;
            end
            S_OUT: begin
                out_sm_tvalid = 1'b1;
                out_sm_tdata  = acc;
                out_sm_tlast  = last_q;
                if (in_sm_tready) begin
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT_IN;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new job starts from an empty buffer at slot 0 and clears the old done.
        if (start_ok) begin
            tap_num_d = in_cfg_tap_num;
            len_d     = in_cfg_data_len;
            cnt_d     = '0;
            k_d       = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            last_d    = 1'b0;
            done_d    = 1'b0;
`ifdef FIR_SCHED_ZERO_INIT_EN
            state_d   = S_CLEAR;
`else
            state_d   = S_WAIT_IN;
`endif
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= S_IDLE;
            tap_num_q <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            k_q       <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            sample_q  <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            mac_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tap_num_q <= tap_num_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            sample_q  <= sample_d;
            last_q    <= last_d;
            done_q    <= done_d;
            mac_en_q  <= mac_en_d;
        end
    end

endmodule

// File: tb/tb_fir_sched.sv
// Directed bench for fir_sched with behavioural tap/data RAMs; works with or
// without FIR_SCHED_ZERO_INIT_EN since results and latency are build-independent.
module tb_fir_sched;

    localparam int DW = 32;
    localparam int TW = 10;
    localparam int NW = 10;
    localparam int LW = 32;

    logic            aclk;
    logic            areset;
    logic            in_cfg_start;
    logic [TW:0]     in_cfg_tap_num;
    logic [LW-1:0]   in_cfg_data_len;
    logic            in_cfg_done_clr;
    logic            out_sts_busy, out_sts_done, out_sts_idle;
    logic            in_ss_tvalid, in_ss_tlast, out_ss_tready;
    logic [DW-1:0]   in_ss_tdata;
    logic            out_sm_tvalid, out_sm_tlast, in_sm_tready;
    logic [DW-1:0]   out_sm_tdata;
    logic            out_tap_EN;
    logic [TW-1:0]   out_tap_A;
    logic [DW-1:0]   in_tap_Do;
    logic            out_data_EN, out_data_WE;
    logic [NW-1:0]   out_data_A;
    logic [DW-1:0]   out_data_Di, in_data_Do;

    logic [DW-1:0]   tap_mem  [0:1023];
    logic [DW-1:0]   data_mem [0:1023];
    logic            garbage_req;

    int n_compared;
    int n_mismatched;

    typedef struct {
        int n;
        int l;
        int coef[11];
        int x[11];
        int y[11];
        int stall_at;
        int restart_at;
    } vec_t;

    vec_t vecs[5];

    int cur_n, cur_l, cur_tlast_at;
    int cur_coef[16];
    int cur_x[600];
    int cur_y[600];

    fir_sched dut (
        .aclk            (aclk),
        .areset          (areset),
        .in_cfg_start    (in_cfg_start),
        .in_cfg_tap_num  (in_cfg_tap_num),
        .in_cfg_data_len (in_cfg_data_len),
        .in_cfg_done_clr (in_cfg_done_clr),
        .out_sts_busy    (out_sts_busy),
        .out_sts_done    (out_sts_done),
        .out_sts_idle    (out_sts_idle),
        .in_ss_tvalid    (in_ss_tvalid),
        .in_ss_tdata     (in_ss_tdata),
        .in_ss_tlast     (in_ss_tlast),
        .out_ss_tready   (out_ss_tready),
        .out_sm_tvalid   (out_sm_tvalid),
        .out_sm_tdata    (out_sm_tdata),
        .out_sm_tlast    (out_sm_tlast),
        .in_sm_tready    (in_sm_tready),
        .out_tap_EN      (out_tap_EN),
        .out_tap_A       (out_tap_A),
        .in_tap_Do       (in_tap_Do),
        .out_data_EN     (out_data_EN),
        .out_data_WE     (out_data_WE),
        .out_data_A      (out_data_A),
        .out_data_Di     (out_data_Di),
        .in_data_Do      (in_data_Do)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Single-port RAM models with one cycle of read latency.
    always @(posedge aclk) begin
        if (out_tap_EN) in_tap_Do <= tap_mem[out_tap_A];
    end

    always @(posedge aclk) begin
        if (garbage_req) begin
            for (int i = 0; i < 1024; i++) data_mem[i] <= $urandom();
        end else if (out_data_EN) begin
            if (out_data_WE) data_mem[out_data_A] <= out_data_Di;
            in_data_Do <= data_mem[out_data_A];
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic cycle();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic fillGarbage();
        garbage_req = 1'b1;
        cycle();
        garbage_req = 1'b0;
    endtask

    task automatic startJob(input int n, input int l);
        in_cfg_tap_num  = (TW + 1)'(n);
        in_cfg_data_len = LW'(l);
        in_cfg_start    = 1'b1;
        cycle();
        in_cfg_start    = 1'b0;
    endtask

    // Presents one sample and returns at the negedge after the handshake edge.
    task automatic waitAccept(input int x, input bit last, output bit ok);
        in_ss_tvalid = 1'b1;
        in_ss_tdata  = x;
        in_ss_tlast  = last;
        ok = 1'b0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            ok = out_ss_tready;
            cycle();
        end
        in_ss_tvalid = 1'b0;
        in_ss_tlast  = 1'b0;
    endtask

    task automatic modelJob(input int num);
        for (int n = 0; n < num; n++) begin
            int s;
            s = 0;
            for (int k = 0; k < cur_n; k++) begin
                if (n - k >= 0) s += cur_coef[k] * cur_x[n - k];
            end
            cur_y[n] = s;
        end
    endtask

    task automatic loadVec(input int v);
        cur_n = vecs[v].n;
        cur_l = vecs[v].l;
        cur_tlast_at = -1;
        for (int k = 0; k < 11; k++) begin
            cur_coef[k] = vecs[v].coef[k];
            cur_x[k]    = vecs[v].x[k];
            cur_y[k]    = vecs[v].y[k];
        end
    endtask

    task automatic applyStimulus(input int stall_at, input int restart_at);
        int  num_feed, wp, cyc, slot, hits;
        bit  ok;
        for (int k = 0; k < cur_n; k++) tap_mem[k] = cur_coef[k];
        num_feed = (cur_tlast_at >= 0) ? cur_tlast_at + 1 : cur_l;
        startJob(cur_n, cur_l);
        checkOutput("busy_on_start", 32'(out_sts_busy), 1);
        checkOutput("idle_on_start", 32'(out_sts_idle), 0);
        checkOutput("done_on_start", 32'(out_sts_done), 0);
        wp = 0;
        for (int i = 0; i < num_feed; i++) begin
            if (i == restart_at) startJob(5, 2);
            waitAccept(cur_x[i], (i == cur_tlast_at), ok);
            checkOutput($sformatf("ss_accept[%0d]", i), 32'(ok), 1);
            if (!ok) return;
            checkOutput($sformatf("write_we[%0d]", i), 32'(out_data_WE), 1);
            checkOutput($sformatf("write_addr[%0d]", i), 32'(out_data_A), wp);
            checkOutput($sformatf("write_data[%0d]", i), out_data_Di, cur_x[i]);
            cyc = 0;
            ok  = 1'b0;
            while (!ok && cyc < 3000) begin
                cycle();
                cyc++;
                if (out_sm_tvalid) begin
                    ok = 1'b1;
                end else if (cyc <= cur_n) begin
                    slot = ((wp - (cyc - 1)) % cur_n + cur_n) % cur_n;
                    checkOutput($sformatf("mac_tap_a[%0d.%0d]", i, cyc - 1), 32'(out_tap_A), cyc - 1);
                    checkOutput($sformatf("mac_data_a[%0d.%0d]", i, cyc - 1), 32'(out_data_A), slot);
                end
            end
            checkOutput($sformatf("latency[%0d]", i), cyc, cur_n + 2);
            if (!ok) return;
            if (i == stall_at) begin
                for (int s = 0; s < 20; s++) begin
                    checkOutput($sformatf("held_tdata[%0d]", s), out_sm_tdata, cur_y[i]);
                    checkOutput($sformatf("held_tvalid[%0d]", s), 32'(out_sm_tvalid), 1);
                    checkOutput($sformatf("held_ss_tready[%0d]", s), 32'(out_ss_tready), 0);
                    cycle();
                end
            end
            checkOutput($sformatf("y[%0d]", i), out_sm_tdata, cur_y[i]);
            checkOutput($sformatf("tlast[%0d]", i), 32'(out_sm_tlast), (i == num_feed - 1) ? 1 : 0);
            in_sm_tready = 1'b1;
            cycle();
            in_sm_tready = 1'b0;
            wp = (wp + 1) % cur_n;
        end
        checkOutput("done_at_end", 32'(out_sts_done), 1);
        checkOutput("busy_at_end", 32'(out_sts_busy), 0);
        checkOutput("idle_at_end", 32'(out_sts_idle), 1);
        hits = 0;
        in_ss_tvalid = 1'b1;
        in_ss_tdata  = 32'h1234;
        for (int t = 0; t < 8; t++) begin
            if (out_ss_tready) hits++;
            cycle();
        end
        in_ss_tvalid = 1'b0;
        checkOutput("no_extra_accept", hits, 0);
    endtask

    initial begin
        bit ok;
        n_compared      = 0;
        n_mismatched    = 0;
        areset          = 1'b1;
        garbage_req     = 1'b0;
        in_cfg_start    = 1'b0;
        in_cfg_tap_num  = '0;
        in_cfg_data_len = '0;
        in_cfg_done_clr = 1'b0;
        in_ss_tvalid    = 1'b0;
        in_ss_tdata     = '0;
        in_ss_tlast     = 1'b0;
        in_sm_tready    = 1'b0;
        for (int i = 0; i < 1024; i++) tap_mem[i] = $urandom();

        vecs[0] = '{11, 11,
                    '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0},
                    '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
                    '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0},
                    -1, -1};
        vecs[1] = '{3, 4,
                    '{1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0},
                    '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0},
                    '{1, 3, 6, 6, 0, 0, 0, 0, 0, 0, 0},
                    1, 2};
        vecs[2] = '{1, 3,
                    '{-5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
                    '{2, -3, 7, 0, 0, 0, 0, 0, 0, 0, 0},
                    '{-10, 15, -35, 0, 0, 0, 0, 0, 0, 0, 0},
                    -1, -1};
        vecs[3] = '{2, 5,
                    '{3, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0},
                    '{4, 5, -2, 0, 10, 0, 0, 0, 0, 0, 0},
                    '{12, 11, -11, 2, 30, 0, 0, 0, 0, 0, 0},
                    -1, -1};
        vecs[4] = '{2, 2,
                    '{32'h7fffffff, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0},
                    '{2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0},
                    '{-2, 32'h80000003, 0, 0, 0, 0, 0, 0, 0, 0, 0},
                    -1, -1};

        @(negedge aclk);
        fillGarbage();
        cycle();
        checkOutput("rst_idle", 32'(out_sts_idle), 1);
        checkOutput("rst_busy", 32'(out_sts_busy), 0);
        checkOutput("rst_done", 32'(out_sts_done), 0);
        checkOutput("rst_ss_tready", 32'(out_ss_tready), 0);
        checkOutput("rst_sm_tvalid", 32'(out_sm_tvalid), 0);
        checkOutput("rst_sm_tdata", out_sm_tdata, 0);
        checkOutput("rst_tap_en", 32'(out_tap_EN), 0);
        checkOutput("rst_data_en", 32'(out_data_EN), 0);
        areset = 1'b0;
        cycle();

        startJob(0, 5);
        checkOutput("n0_idle", 32'(out_sts_idle), 1);
        checkOutput("n0_busy", 32'(out_sts_busy), 0);
        checkOutput("n0_ss_tready", 32'(out_ss_tready), 0);
        startJob(3, 0);
        checkOutput("l0_idle", 32'(out_sts_idle), 1);
        checkOutput("l0_busy", 32'(out_sts_busy), 0);

        for (int v = 0; v < 5; v++) begin
            loadVec(v);
            applyStimulus(vecs[v].stall_at, vecs[v].restart_at);
        end

        startJob(0, 4);
        checkOutput("n0_keeps_done", 32'(out_sts_done), 1);
        checkOutput("n0_keeps_idle", 32'(out_sts_idle), 1);
        in_cfg_done_clr = 1'b1;
        cycle();
        in_cfg_done_clr = 1'b0;
        checkOutput("done_cleared", 32'(out_sts_done), 0);

        cur_n = 3;
        cur_l = 600;
        cur_tlast_at = 99;
        cur_coef[0] = 4;
        cur_coef[1] = -3;
        cur_coef[2] = 2;
        for (int i = 0; i < 600; i++) cur_x[i] = (i * 7) % 13 - 6;
        modelJob(100);
        applyStimulus(-1, -1);

        fillGarbage();
        for (int k = 0; k < 11; k++) tap_mem[k] = vecs[0].coef[k];
        startJob(11, 11);
        waitAccept(5, 1'b0, ok);
        checkOutput("mid_accept", 32'(ok), 1);
        repeat (3) cycle();
        checkOutput("mid_in_mac", 32'(out_tap_EN), 1);
        areset = 1'b1;
        cycle();
        checkOutput("mid_rst_tap_en", 32'(out_tap_EN), 0);
        checkOutput("mid_rst_data_en", 32'(out_data_EN), 0);
        checkOutput("mid_rst_data_we", 32'(out_data_WE), 0);
        checkOutput("mid_rst_sm_tvalid", 32'(out_sm_tvalid), 0);
        checkOutput("mid_rst_sm_tdata", out_sm_tdata, 0);
        checkOutput("mid_rst_sm_tlast", 32'(out_sm_tlast), 0);
        checkOutput("mid_rst_ss_tready", 32'(out_ss_tready), 0);
        checkOutput("mid_rst_busy", 32'(out_sts_busy), 0);
        checkOutput("mid_rst_done", 32'(out_sts_done), 0);
        checkOutput("mid_rst_idle", 32'(out_sts_idle), 1);
        areset = 1'b0;
        cycle();
        loadVec(0);
        applyStimulus(-1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
